// File: rtl/xm23_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller.
//   state_e       : redirect controller FSM states
//   src_t         : served-source encoding (ordered so a larger value means higher priority)
//   PC_W_DEF      : default PC/address width
//   LR_ALIGN_MASK : mask that clears LR bit 0 for word alignment (slice to PC width)
package xm23_ctrl_pkg;

  localparam int unsigned PC_W_DEF = 16;

  // Wide enough for any PC width; users slice [PC_W-1:0].
  localparam logic [63:0] LR_ALIGN_MASK = ~64'd1;

  typedef logic [1:0] src_t;

  localparam src_t SRC_NONE = 2'b00;
  localparam src_t SRC_BR   = 2'b01;
  localparam src_t SRC_LINK = 2'b10;
  localparam src_t SRC_EXC  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StLoad,
    StFlush
  } state_e;

endpackage

// File: rtl/redirect_prio_enc.sv
// Combinational 3-way redirect priority encoder: exception > link-back > branch.
// Ports:
//   exc_req_i / exc_vec_i      : exception request and vector
//   link_back_i / lr_i         : link-back request and link register (bit 0 cleared on output)
//   br_req_i / br_target_i     : taken-branch request and target
//   req_o                      : any request present
//   src_o / target_o           : winning source and its target (SRC_NONE / 0 when idle)
module redirect_prio_enc
  import xm23_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            exc_req_i,
  input  logic [PC_W-1:0] exc_vec_i,
  input  logic            link_back_i,
  input  logic [PC_W-1:0] lr_i,
  input  logic            br_req_i,
  input  logic [PC_W-1:0] br_target_i,
  output logic            req_o,
  output src_t            src_o,
  output logic [PC_W-1:0] target_o
);

  always_comb begin
    req_o    = exc_req_i | link_back_i | br_req_i;
    src_o    = SRC_NONE;
    target_o = '0;
    if (exc_req_i) begin
      src_o    = SRC_EXC;
      target_o = exc_vec_i;
    end else if (link_back_i) begin
      src_o    = SRC_LINK;
      target_o = lr_i & LR_ALIGN_MASK[PC_W-1:0];
    end else if (br_req_i) begin
      src_o    = SRC_BR;
      target_o = br_target_i;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates exception, link-back and branch redirects onto the
// single fetch PC load port, then flushes/stalls fetch for FLUSH_CYCLES after each load.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   exc_req_i, exc_vec_i           : exception request / vector
//   link_back_i, LR_i              : link-back request / link register
//   br_req_i, br_target_i          : taken branch request / target
//   mem_busy_i                     : memory stage busy, defers the PC load
//   pc_load_o, pc_target_o, src_o  : PC load strobe, target, served source
//   flush_o, stall_fetch_o, busy_o : squash fetch/decode, hold fetch, controller not idle
module pc_redirect_ctrl
  import xm23_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = PC_W_DEF,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          EXC_HOLD     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req_i,
  input  logic [PC_W-1:0] exc_vec_i,
  input  logic            link_back_i,
  input  logic [PC_W-1:0] LR_i,
  input  logic            br_req_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            mem_busy_i,
  output logic            pc_load_o,
  output logic [PC_W-1:0] pc_target_o,
  output logic            flush_o,
  output logic            stall_fetch_o,
  output logic [1:0]      src_o,
  output logic            busy_o
);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] tgt_q, tgt_d;            // accepted / pending target
  src_t            src_q, src_d;
  logic [PC_W-1:0] last_tgt_q, last_tgt_d;  // held on the outputs outside LOAD
  src_t            last_src_q, last_src_d;
  logic            exc_pend_q, exc_pend_d;

  logic            win_req;
  src_t            win_src;
  logic [PC_W-1:0] win_tgt;
  logic            exc_take;

  redirect_prio_enc #(
    .PC_W(PC_W)
  ) u_prio (
    .exc_req_i  (exc_req_i),
    .exc_vec_i  (exc_vec_i),
    .link_back_i(link_back_i),
    .lr_i       (LR_i),
    .br_req_i   (br_req_i),
    .br_target_i(br_target_i),
    .req_o      (win_req),
    .src_o      (win_src),
    .target_o   (win_tgt)
  );

  assign exc_take = EXC_HOLD && exc_req_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    src_d      = src_q;
    last_tgt_d = last_tgt_q;
    last_src_d = last_src_q;
    exc_pend_d = exc_pend_q;
    unique case (state_q)
      StIdle: begin
        if (win_req) begin
          tgt_d   = win_tgt;
          src_d   = win_src;
          state_d = mem_busy_i ? StWait : StLoad;
        end
      end
      StWait: begin
        // Source encoding is priority-ordered, so a plain compare decides replacement.
        if (win_src > src_q) begin
          tgt_d = win_tgt;
          src_d = win_src;
        end
        if (!mem_busy_i) state_d = StLoad;
      end
      StLoad: begin
        last_tgt_d = tgt_q;
        last_src_d = src_q;
        cnt_d      = 3'(FLUSH_CYCLES);
        exc_pend_d = 1'b0;
        state_d    = StFlush;
      end
      StFlush: begin
        cnt_d = cnt_q - 3'd1;
        // Link/branch requests here are wrong-path and ignored; only exceptions are kept.
        if (exc_take) begin
          exc_pend_d = 1'b1;
          tgt_d      = exc_vec_i;
          src_d      = SRC_EXC;
        end
        if (cnt_q == 3'd1) begin
          exc_pend_d = 1'b0;
          if (exc_pend_q || exc_take) state_d = mem_busy_i ? StWait : StLoad;
          else                        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tgt_q      <= '0;
      src_q      <= SRC_NONE;
      last_tgt_q <= '0;
      last_src_q <= SRC_NONE;
      exc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      src_q      <= src_d;
      last_tgt_q <= last_tgt_d;
      last_src_q <= last_src_d;
      exc_pend_q <= exc_pend_d;
    end
  end

  always_comb begin
    pc_load_o     = (state_q == StLoad);
    pc_target_o   = pc_load_o ? tgt_q : last_tgt_q;
    src_o         = pc_load_o ? src_q : last_src_q;
    flush_o       = (state_q == StLoad) || (state_q == StFlush);
    stall_fetch_o = flush_o || (state_q == StWait);
    busy_o        = (state_q != StIdle);
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Arbitrates the three PC-redirect requesters: the exception unit, the link-back detector (LD from 0xFFFF at execute) and taken branches.
- Owns the single fetch-unit PC load port.
- After each redirect it sequences a pipeline flush and fetch stall of fixed length, so wrong-path instructions cannot issue further redirects.
- Sits between the execute-stage decoders and the fetch/PC register, alongside the GPRC/LR datapath.

Parameters:
- PC_W, 16, PC/address width.
- FLUSH_CYCLES, 2, cycles fetch/decode remain flushed after a PC load (1..7).
- EXC_HOLD, 1, 1 = latch an exception arriving during flush and serve it afterwards; 0 = drop it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- exc_req_i  in  1  exception/interrupt redirect request (level)
- exc_vec_i  in  PC_W  exception vector address
- link_back_i  in  1  link-back request from the execute-stage LR detector
- LR_i  in  PC_W  current link register value
- br_req_i  in  1  taken-branch request from execute
- br_target_i  in  PC_W  branch target
- mem_busy_i  in  1  memory stage busy; a PC load may not be issued
- pc_load_o  out  1  one-cycle PC load strobe
- pc_target_o  out  PC_W  target address, valid while pc_load_o is high
- flush_o  out  1  squash fetch/decode contents
- stall_fetch_o  out  1  hold fetch
- src_o  out  2  served source: 00 none, 01 branch, 10 link, 11 exception
- busy_o  out  1  controller not in IDLE

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; pc_target_o = 0; pending register cleared; flush counter = 0.
- Priority: exception > link-back > branch. Only the winner is served. Losers are dropped, not queued.
- Target selection:
  - Exception: exc_vec_i.
  - Link-back: LR_i with bit 0 forced to 0 (word alignment).
  - Branch: br_target_i unmodified.
- Target and source are latched on the accept cycle.
- IDLE:
  - A request with mem_busy_i = 0 goes to LOAD on the next edge.
  - A request with mem_busy_i = 1 latches the winner into the pending register and goes to WAIT.
- WAIT:
  - stall_fetch_o = 1.
  - A new request of higher priority than the pending one replaces it. Equal or lower priority requests are ignored.
  - Goes to LOAD on the first cycle with mem_busy_i = 0.
- LOAD (exactly 1 cycle):
  - pc_load_o = 1; pc_target_o and src_o = latched values; flush_o = 1; stall_fetch_o = 1.
  - Counter loads FLUSH_CYCLES; next state FLUSH.
- FLUSH:
  - flush_o = 1 and stall_fetch_o = 1 while the counter is nonzero; counter decrements each cycle.
  - At 0, goes to IDLE, or to LOAD if an exception is pending (EXC_HOLD = 1) and mem_busy_i = 0, or to WAIT if it is pending and mem_busy_i = 1.
  - Link and branch requests in FLUSH are discarded (wrong path).
- Latency: IDLE request to pc_load_o is 1 cycle. Total redirect shadow is 1 + FLUSH_CYCLES cycles.
- Simultaneous requests in the same cycle: only the priority winner is served; src_o reflects it.
- mem_busy_i rising in LOAD or FLUSH has no effect on the current redirect.
- src_o and pc_target_o hold their last value outside LOAD; they are 0 after reset.
- Reset asserted mid-FLUSH or mid-WAIT: returns to IDLE immediately; the pending request is lost.
- busy_o = (state != IDLE).

Decomposition:
- Package xm23_ctrl_pkg:
  - state enum (IDLE, WAIT, LOAD, FLUSH)
  - src encoding constants (SRC_NONE, SRC_BR, SRC_LINK, SRC_EXC)
  - PC_W default and the LR alignment mask constant
- Sub-module redirect_prio_enc: combinational 3-way priority encoder producing winner src and target, including the LR bit-0 clear. The same block is reused by the WAIT-state replacement compare.

Test Plan:
- br_req_i=1, br_target_i=0x0200, mem_busy_i=0 in IDLE -> next cycle pc_load_o=1, pc_target_o=0x0200, src_o=01; then flush_o=1 for 2 cycles; busy_o low on cycle 4.
- link_back_i=1, LR_i=0x1235 -> pc_target_o=0x1234, src_o=10.
- exc_req_i, link_back_i and br_req_i all asserted in the same cycle with exc_vec_i=0xFFE0 -> exactly one pc_load_o, target 0xFFE0, src_o=11; no second load follows.
- Branch while mem_busy_i=1 for 3 cycles, then link_back_i asserted in cycle 2 of WAIT -> stall_fetch_o high throughout; a single load with LR target once busy drops.
- Exception asserted during FLUSH with EXC_HOLD=1 -> second pc_load_o immediately after the flush ends, target exc_vec_i. Branch asserted during FLUSH -> no load.
- rst asserted mid-FLUSH -> all outputs 0 asynchronously; after release, the FSM is IDLE and a new request is served normally.
